// File: rtl/sdram_arbit.sv
// SDRAM command bus arbiter: grants init / auto-refresh / write / read access and muxes the granted bus onto the pins.
// Optional build macro SDRAM_ARBIT_RR_EN: round-robin between write and read when both request (default: fixed aref > write > read).
module sdram_arbit #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned BA_W   = 2,
  parameter int unsigned DATA_W = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [3:0]        init_cmd,
  input  logic [BA_W-1:0]   init_ba,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic              init_end,
  input  logic              aref_req,
  input  logic [3:0]        aref_cmd,
  input  logic [BA_W-1:0]   aref_ba,
  input  logic [ADDR_W-1:0] aref_addr,
  input  logic              aref_end,
  output logic              aref_en,
  input  logic              wr_req,
  input  logic [3:0]        wr_cmd,
  input  logic [BA_W-1:0]   wr_ba,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_sdram_en,
  input  logic              wr_end,
  output logic              wr_en,
  input  logic              rd_req,
  input  logic [3:0]        rd_cmd,
  input  logic [BA_W-1:0]   rd_ba,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_end,
  output logic              rd_en,
  output logic              sdram_cke,
  output logic              sdram_cs_n,
  output logic              sdram_ras_n,
  output logic              sdram_cas_n,
  output logic              sdram_we_n,
  output logic [BA_W-1:0]   sdram_ba,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [DATA_W-1:0] sdram_dq_out,
  output logic              sdram_dq_oe
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARBIT = 3'd1,
    AREF  = 3'd2,
    WRITE = 3'd3,
    READ  = 3'd4
  } state_t;

  localparam logic [3:0] CMD_NOP = 4'b0111;

  state_t state, state_nxt;
  logic              both_pick_rd;
  logic [3:0]        cmd_sel;
  logic [BA_W-1:0]   ba_sel;
  logic [ADDR_W-1:0] addr_sel;

  // State register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

`ifdef SDRAM_ARBIT_RR_EN
  // 1 = write was granted last, 0 = read was granted last
  logic last_grant;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      last_grant <= 1'b0;
    end else if (state == ARBIT) begin
      if (state_nxt == WRITE)     last_grant <= 1'b1;
      else if (state_nxt == READ) last_grant <= 1'b0;
    end
  end

  assign both_pick_rd = last_grant;
`else
  assign both_pick_rd = 1'b0;
`endif

  // Next-state logic; refresh always wins, bursts run to their end pulse
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (init_end) state_nxt = ARBIT;
      ARBIT: begin
        if (aref_req)                          state_nxt = AREF;
        else if (wr_req && rd_req)             state_nxt = both_pick_rd ? READ : WRITE;
        else if (wr_req)                       state_nxt = WRITE;
        else if (rd_req)                       state_nxt = READ;
      end
      AREF:  if (aref_end) state_nxt = ARBIT;
      WRITE: if (wr_end)   state_nxt = ARBIT;
      READ:  if (rd_end)   state_nxt = ARBIT;
      default:             state_nxt = IDLE;
    endcase
  end

  // Bus select decoded from the state register
  always_comb begin
    cmd_sel  = CMD_NOP;
    ba_sel   = '0;
    addr_sel = '0;
    case (state)
      IDLE:  begin cmd_sel = init_cmd; ba_sel = init_ba; addr_sel = init_addr; end
      AREF:  begin cmd_sel = aref_cmd; ba_sel = aref_ba; addr_sel = aref_addr; end
      WRITE: begin cmd_sel = wr_cmd;   ba_sel = wr_ba;   addr_sel = wr_addr;   end
      READ:  begin cmd_sel = rd_cmd;   ba_sel = rd_ba;   addr_sel = rd_addr;   end
      default: ;
    endcase
  end

  assign aref_en = (state == AREF);
  assign wr_en   = (state == WRITE);
  assign rd_en   = (state == READ);

  // Reset forces the pins to NOP immediately, even though IDLE normally passes the init bus
  assign sdram_cke = sys_rst_n;
  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = sys_rst_n ? cmd_sel : CMD_NOP;
  assign sdram_ba     = sys_rst_n ? ba_sel   : '0;
  assign sdram_addr   = sys_rst_n ? addr_sel : '0;
  assign sdram_dq_out = sys_rst_n ? wr_data  : '0;
  assign sdram_dq_oe  = (state == WRITE) && wr_sdram_en;

endmodule

// File: tb/tb_sdram_arbit.sv
// Directed bench for sdram_arbit: grant order, bus mux, write data path and asynchronous reset.
module tb_sdram_arbit;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic [3:0]  init_cmd, aref_cmd, wr_cmd, rd_cmd;
  logic [1:0]  init_ba, aref_ba, wr_ba, rd_ba;
  logic [12:0] init_addr, aref_addr, wr_addr, rd_addr;
  logic        init_end, aref_req, aref_end, wr_req, wr_sdram_en, wr_end, rd_req, rd_end;
  logic [15:0] wr_data;
  logic        aref_en, wr_en, rd_en;
  logic        sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
  logic [1:0]  sdram_ba;
  logic [12:0] sdram_addr;
  logic [15:0] sdram_dq_out;
  logic        sdram_dq_oe;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [2:0] G_NONE = 3'b000;
  localparam logic [2:0] G_AREF = 3'b100;
  localparam logic [2:0] G_WR   = 3'b010;
  localparam logic [2:0] G_RD   = 3'b001;

  sdram_arbit dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .init_cmd(init_cmd), .init_ba(init_ba), .init_addr(init_addr), .init_end(init_end),
    .aref_req(aref_req), .aref_cmd(aref_cmd), .aref_ba(aref_ba), .aref_addr(aref_addr),
    .aref_end(aref_end), .aref_en(aref_en),
    .wr_req(wr_req), .wr_cmd(wr_cmd), .wr_ba(wr_ba), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_sdram_en(wr_sdram_en), .wr_end(wr_end), .wr_en(wr_en),
    .rd_req(rd_req), .rd_cmd(rd_cmd), .rd_ba(rd_ba), .rd_addr(rd_addr),
    .rd_end(rd_end), .rd_en(rd_en),
    .sdram_cke(sdram_cke), .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n),
    .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n), .sdram_ba(sdram_ba),
    .sdram_addr(sdram_addr), .sdram_dq_out(sdram_dq_out), .sdram_dq_oe(sdram_dq_oe)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pins_obs();
    return {12'h0, sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_ba, sdram_addr};
  endfunction

  function automatic logic [31:0] pins_exp(input logic cke, input logic [3:0] cmd,
                                           input logic [1:0] ba, input logic [12:0] addr);
    return {12'h0, cke, cmd, ba, addr};
  endfunction

  function automatic logic [31:0] grants();
    return {29'h0, aref_en, wr_en, rd_en};
  endfunction

  initial begin
    logic [2:0] exp_seq [4];
    sys_rst_n = 1'b0;
    init_cmd = 4'b0010; init_ba = 2'd1; init_addr = 13'h0400;
    aref_cmd = 4'b0001; aref_ba = 2'd2; aref_addr = 13'h0011;
    wr_cmd   = 4'b0100; wr_ba   = 2'd3; wr_addr   = 13'h0222;
    rd_cmd   = 4'b0101; rd_ba   = 2'd1; rd_addr   = 13'h0333;
    init_end = 0; aref_req = 0; aref_end = 0; wr_req = 0; wr_end = 0; rd_req = 0; rd_end = 0;
    wr_sdram_en = 1'b1; wr_data = 16'h1234;

    // Reset values
    #3;
    chk("rst_grants", grants(), 32'(G_NONE));
    chk("rst_pins", pins_obs(), pins_exp(1'b0, 4'b0111, 2'd0, 13'h0));
    chk("rst_dq", {15'h0, sdram_dq_oe, sdram_dq_out}, 32'h0);
    #20 sys_rst_n = 1'b1;
    wr_sdram_en = 1'b0;

    // IDLE for 100 cycles: init bus on the pins
    for (int i = 0; i < 100; i++) step();
    chk("idle_pins", pins_obs(), pins_exp(1'b1, 4'b0010, 2'd1, 13'h0400));
    chk("idle_grants", grants(), 32'(G_NONE));
    init_end = 1'b1;
    #1 chk("idle_pins_init_end", pins_obs(), pins_exp(1'b1, 4'b0010, 2'd1, 13'h0400));
    step();
    chk("arbit_nop", pins_obs(), pins_exp(1'b1, 4'b0111, 2'd0, 13'h0));
    chk("arbit_grants", grants(), 32'(G_NONE));
    init_end = 1'b0;
    step();
    chk("init_end_fall_ignored", pins_obs(), pins_exp(1'b1, 4'b0111, 2'd0, 13'h0));

    // Refresh beats write when both request together
    aref_req = 1'b1; wr_req = 1'b1;
    step();
    chk("aref_first", grants(), 32'(G_AREF));
    chk("aref_pins", pins_obs(), pins_exp(1'b1, 4'b0001, 2'd2, 13'h0011));
    aref_req = 1'b0;
    step();
    chk("aref_hold", grants(), 32'(G_AREF));
    aref_end = 1'b1;
    step();
    aref_end = 1'b0;
    chk("aref_to_arbit", grants(), 32'(G_NONE));
    step();
    chk("wr_after_aref", grants(), 32'(G_WR));
    chk("wr_pins", pins_obs(), pins_exp(1'b1, 4'b0100, 2'd3, 13'h0222));

    // Write data path, stray end pulses and a read request mid-burst
    wr_req = 1'b0; rd_req = 1'b1; wr_sdram_en = 1'b1; wr_data = 16'hA5A5;
    #1 chk("dq_during_write", {15'h0, sdram_dq_oe, sdram_dq_out}, 32'h1A5A5);
    rd_end = 1'b1; aref_end = 1'b1;
    step();
    rd_end = 1'b0; aref_end = 1'b0;
    chk("stray_end_ignored", grants(), 32'(G_WR));
    wr_end = 1'b1;
    step();
    wr_end = 1'b0;
    chk("wr_end_arbit", grants(), 32'(G_NONE));
    chk("dq_oe_off_outside_write", {31'h0, sdram_dq_oe}, 32'h0);
    wr_sdram_en = 1'b0;
    step();
    chk("rd_after_wr_end", grants(), 32'(G_RD));
    chk("rd_pins", pins_obs(), pins_exp(1'b1, 4'b0101, 2'd1, 13'h0333));

    // Refresh arriving during a read waits, then beats the pending write
    aref_req = 1'b1; wr_req = 1'b1;
    step();
    chk("no_preempt", grants(), 32'(G_RD));
    rd_end = 1'b1; rd_req = 1'b0;
    step();
    rd_end = 1'b0;
    chk("rd_end_arbit", grants(), 32'(G_NONE));
    step();
    chk("aref_before_wr", grants(), 32'(G_AREF));
    aref_req = 1'b0; aref_end = 1'b1;
    step();
    aref_end = 1'b0;
    step();
    chk("wr_served_after_aref", grants(), 32'(G_WR));

    // Asynchronous reset mid-write
    wr_req = 1'b0; wr_sdram_en = 1'b1;
    #2 sys_rst_n = 1'b0;
    #1;
    chk("midrst_grants", grants(), 32'(G_NONE));
    chk("midrst_pins", pins_obs(), pins_exp(1'b0, 4'b0111, 2'd0, 13'h0));
    chk("midrst_dq", {15'h0, sdram_dq_oe, sdram_dq_out}, 32'h0);
    #4 sys_rst_n = 1'b1;
    wr_sdram_en = 1'b0;
    step();
    chk("post_rst_idle", pins_obs(), pins_exp(1'b1, 4'b0010, 2'd1, 13'h0400));

    // Write and read both held for four grants
`ifdef SDRAM_ARBIT_RR_EN
    exp_seq = '{G_WR, G_RD, G_WR, G_RD};
`else
    exp_seq = '{G_WR, G_WR, G_WR, G_WR};
`endif
    wr_req = 1'b1; rd_req = 1'b1; init_end = 1'b1;
    step();
    chk("rr_arbit", grants(), 32'(G_NONE));
    for (int g = 0; g < 4; g++) begin
      step();
      chk($sformatf("grant_%0d", g), grants(), 32'(exp_seq[g]));
      if (exp_seq[g] == G_WR) wr_end = 1'b1;
      else                    rd_end = 1'b1;
      step();
      wr_end = 1'b0; rd_end = 1'b0;
      chk($sformatf("grant_%0d_done", g), grants(), 32'(G_NONE));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
